// File: rtl/gshare_predictor_if.sv
// rtl/gshare_predictor_if.sv - fetch-query and writeback-train signal bundle for gshare_predictor
interface gshare_predictor_if #(
  parameter int HIST_W = 4
);
  logic [15:0]       PC_if;
  logic              predict_req;
  logic              predict_taken;
  logic [HIST_W-1:0] branch_hist_if;
  logic              ready;
  logic              update_valid;
  logic [15:0]       PC_wb;
  logic [HIST_W-1:0] branch_hist_wb;
  logic              taken_wb;
  logic              mispredict_wb;

  modport master (
    output PC_if, predict_req, update_valid, PC_wb, branch_hist_wb, taken_wb, mispredict_wb,
    input  predict_taken, branch_hist_if, ready
  );

  modport slave (
    input  PC_if, predict_req, update_valid, PC_wb, branch_hist_wb, taken_wb, mispredict_wb,
    output predict_taken, branch_hist_if, ready
  );
endinterface

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare direction predictor with speculative history and post-reset table init
module gshare_predictor #(
  parameter int HIST_W     = 4,
  parameter int INDEX_BITS = 5,
  parameter int CTR_W      = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  gshare_predictor_if.slave  bus
);
  localparam int              DEPTH    = 1 << INDEX_BITS;
  localparam logic [CTR_W-1:0] CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};

  typedef enum logic {INIT, RUN} state_t;

  state_t                  state, state_nxt;
  logic [INDEX_BITS-1:0]   init_ptr;
  logic [HIST_W-1:0]       spec_hist, hist_nxt;
  logic [CTR_W-1:0]        ctr_table [DEPTH];
  logic [INDEX_BITS-1:0]   pred_idx, upd_idx, wr_idx;
  logic [CTR_W-1:0]        pred_ctr, upd_ctr, wr_data;
  logic                    wr_en;
  logic                    unused_pc_bits;

  function automatic logic [INDEX_BITS-1:0] table_idx(input logic [15:0] pc,
                                                      input logic [HIST_W-1:0] h);
    return pc[INDEX_BITS:1] ^ (INDEX_BITS'(h) << (INDEX_BITS - HIST_W));
  endfunction

  assign pred_idx = table_idx(bus.PC_if, spec_hist);
  assign upd_idx  = table_idx(bus.PC_wb, bus.branch_hist_wb);
  assign pred_ctr = ctr_table[pred_idx];
  assign upd_ctr  = ctr_table[upd_idx];

  assign bus.ready          = (state == RUN);
  assign bus.predict_taken  = pred_ctr[CTR_W-1] & bus.ready;
  assign bus.branch_hist_if = spec_hist;

  assign unused_pc_bits = ^{bus.PC_if[15:INDEX_BITS+1], bus.PC_if[0],
                            bus.PC_wb[15:INDEX_BITS+1], bus.PC_wb[0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= INIT;
      init_ptr  <= '0;
      spec_hist <= '0;
    end else begin
      state     <= state_nxt;
      spec_hist <= hist_nxt;
      if (state == INIT) init_ptr <= init_ptr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    hist_nxt  = spec_hist;
    wr_en     = 1'b0;
    wr_idx    = init_ptr;
    wr_data   = CTR_WNT;
    case (state)
      INIT: begin
        wr_en = 1'b1;
        if (&init_ptr) state_nxt = RUN;
      end
      RUN: begin
        if (bus.update_valid && enable) begin
          wr_idx = upd_idx;
          if (bus.taken_wb && upd_ctr != CTR_MAX) begin
            wr_en   = 1'b1;
            wr_data = upd_ctr + CTR_W'(1);
          end else if (!bus.taken_wb && upd_ctr != '0) begin
            wr_en   = 1'b1;
            wr_data = upd_ctr - CTR_W'(1);
          end
        end
        // Repair from the resolved branch's own history outranks this cycle's speculative shift.
        if (bus.update_valid && bus.mispredict_wb)
          hist_nxt = {bus.branch_hist_wb[HIST_W-2:0], bus.taken_wb};
        else if (bus.predict_req)
          hist_nxt = {spec_hist[HIST_W-2:0], bus.predict_taken};
      end
      default: state_nxt = INIT;
    endcase
  end

  // Counter storage has no reset; INIT fills it before it is ever trusted.
  always_ff @(posedge clk) begin
    if (wr_en) ctr_table[wr_idx] <= wr_data;
  end
endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - self-checking bench for gshare_predictor
module tb_gshare_predictor;
  localparam int HW    = 4;
  localparam int IB    = 5;
  localparam int CW    = 2;
  localparam int DEPTH = 32;
  localparam int CMAX  = 3;
  localparam int HALF  = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  gshare_predictor_if #(.HIST_W(HW)) bus();
  gshare_predictor #(.HIST_W(HW), .INDEX_BITS(IB), .CTR_W(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int mtab[DEPTH];
  int mhist = 0;
  bit mready = 1'b0;
  int mptr = 0;

  typedef struct {
    int pc; bit req; bit uv; int pcwb; int hwb; bit tk; bit misp; bit en; int ept; int eh;
  } vec_t;
  vec_t vt[$];

  function automatic int idx(input int pc, input int h);
    return ((pc >> 1) % DEPTH) ^ ((h * 2) % DEPTH);
  endfunction

  function automatic vec_t mk(int pc, bit req, bit uv, int pcwb, int hwb, bit tk, bit misp,
                              bit en, int ept, int eh);
    vec_t v;
    v.pc = pc; v.req = req; v.uv = uv; v.pcwb = pcwb; v.hwb = hwb;
    v.tk = tk; v.misp = misp; v.en = en; v.ept = ept; v.eh = eh;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int pc, input bit req, input bit uv, input int pcwb, input int hwb,
                       input bit tk, input bit misp, input bit en);
    bus.PC_if          = 16'(pc);
    bus.predict_req    = req;
    bus.update_valid   = uv;
    bus.PC_wb          = 16'(pcwb);
    bus.branch_hist_wb = 4'(hwb);
    bus.taken_wb       = tk;
    bus.mispredict_wb  = misp;
    enable             = en;
  endtask

  task automatic model_step(input int pt);
    int i, u;
    if (!mready) begin
      mtab[mptr] = HALF - 1;
      mptr++;
      if (mptr == DEPTH) mready = 1'b1;
    end else begin
      if (bus.update_valid && enable) begin
        i = idx(int'(bus.PC_wb), int'(bus.branch_hist_wb));
        u = mtab[i];
        mtab[i] = bus.taken_wb ? ((u + 1 > CMAX) ? CMAX : u + 1) : ((u - 1 < 0) ? 0 : u - 1);
      end
      if (bus.update_valid && bus.mispredict_wb)
        mhist = (int'(bus.branch_hist_wb) * 2 + int'(bus.taken_wb)) % 16;
      else if (bus.predict_req)
        mhist = (mhist * 2 + pt) % 16;
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle(input string tag, input bit use_exp, input int ept, input int eh);
    int pt;
    #1;
    pt = (mready && mtab[idx(int'(bus.PC_if), mhist)] >= HALF) ? 1 : 0;
    check({tag, "_ready"}, int'(bus.ready), int'(mready));
    check({tag, "_taken"}, int'(bus.predict_taken), use_exp ? ept : pt);
    check({tag, "_hist"}, int'(bus.branch_hist_if), use_exp ? eh : mhist);
    model_step(pt);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b0;
    #1;
    check("reset_ready", int'(bus.ready), 0);
    check("reset_taken", int'(bus.predict_taken), 0);
    check("reset_hist", int'(bus.branch_hist_if), 0);
    mready = 1'b0; mptr = 0; mhist = 0;
    repeat (hold) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic init_phase(input int n);
    for (int c = 0; c < n; c++) begin
      drive($urandom, $urandom_range(0, 1), 1'b1, $urandom, $urandom_range(0, 15),
            $urandom_range(0, 1), 1'b1, 1'b1);
      cycle("init", 1'b0, 0, 0);
    end
  endtask

  task automatic sweep_wnt();
    for (int i = 0; i < DEPTH; i++) begin
      drive(i * 2, 1'b0, 1'b1, i * 2, 0, 1'b1, 1'b0, 1'b1);
      cycle("wnt_pre", 1'b1, 0, 0);
      drive(i * 2, 1'b0, 1'b1, i * 2, 0, 1'b0, 1'b0, 1'b1);
      cycle("wnt_post", 1'b1, 1, 0);
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    do_reset(2);
    init_phase(DEPTH);
    sweep_wnt();

    // Saturating training at idx 0
    for (int k = 0; k < 2; k++) vt.push_back(mk(16'h40, 0, 1, 16'h40, 0, 1, 0, 1, k, 0));
    vt.push_back(mk(16'h40, 0, 1, 16'h40, 0, 1, 0, 1, 1, 0));
    vt.push_back(mk(16'h40, 0, 1, 16'h40, 0, 0, 0, 1, 1, 0));
    vt.push_back(mk(16'h40, 0, 1, 16'h40, 0, 0, 0, 1, 1, 0));
    vt.push_back(mk(16'h40, 0, 1, 16'h40, 0, 0, 0, 1, 0, 0));
    vt.push_back(mk(16'h40, 0, 1, 16'h40, 0, 0, 0, 1, 0, 0));
    vt.push_back(mk(16'h40, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    vt.push_back(mk(16'h40, 0, 1, 16'h40, 0, 1, 0, 1, 0, 0));
    vt.push_back(mk(16'h40, 0, 1, 16'h40, 0, 1, 0, 1, 0, 0));
    vt.push_back(mk(16'h40, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    // Speculative shifts 1,0,1,1
    vt.push_back(mk(16'h40, 1, 0, 0, 0, 0, 0, 1, 1, 0));
    vt.push_back(mk(16'h02, 1, 0, 0, 0, 0, 0, 1, 0, 1));
    vt.push_back(mk(16'h08, 1, 0, 0, 0, 0, 0, 1, 1, 2));
    vt.push_back(mk(16'h14, 1, 0, 0, 0, 0, 0, 1, 1, 5));
    vt.push_back(mk(16'h14, 0, 0, 0, 0, 0, 0, 1, 0, 11));
    // Repair beats same-cycle predict_req
    vt.push_back(mk(16'h00, 1, 1, 16'h40, 2, 1, 1, 1, 0, 11));
    vt.push_back(mk(16'h00, 0, 0, 0, 0, 0, 0, 1, 0, 5));
    // Read-before-write, then enable gating
    vt.push_back(mk(16'h00, 0, 1, 16'h00, 5, 1, 0, 1, 0, 5));
    vt.push_back(mk(16'h00, 0, 0, 0, 0, 0, 0, 1, 1, 5));
    vt.push_back(mk(16'h02, 0, 1, 16'h02, 5, 1, 0, 0, 0, 5));
    vt.push_back(mk(16'h02, 0, 0, 0, 0, 0, 0, 1, 0, 5));
    vt.push_back(mk(16'h02, 0, 1, 16'h02, 5, 1, 0, 1, 0, 5));
    vt.push_back(mk(16'h02, 0, 0, 0, 0, 0, 0, 1, 1, 5));
    foreach (vt[i]) begin
      drive(vt[i].pc, vt[i].req, vt[i].uv, vt[i].pcwb, vt[i].hwb, vt[i].tk, vt[i].misp, vt[i].en);
      cycle($sformatf("vec%0d", i), 1'b1, vt[i].ept, vt[i].eh);
    end

    for (int c = 0; c < 400; c++) begin
      drive($urandom, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 63),
            $urandom_range(0, 15), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) != 0));
      cycle("rand", 1'b0, 0, 0);
    end

    do_reset(1);
    init_phase(10);
    do_reset(2);
    init_phase(DEPTH);
    sweep_wnt();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
